// File: rtl/pipe_ripple_adder_pkg.sv
// Shared types and the full-adder cell that every segment ripple chain is built from.
package pipe_ripple_adder_pkg;

  typedef struct packed {
    logic cout;
    logic sum;
  } fa_t;

  function automatic fa_t full_add(input logic a, input logic b, input logic cin);
    fa_t r;
    r.sum  = a ^ b ^ cin;
    r.cout = (a & b) | (cin & (a ^ b));
    return r;
  endfunction

endpackage

// File: rtl/pipe_ripple_adder_seg_ripple.sv
// Combinational SEG-bit ripple chain; also exposes the carry into its top bit for overflow.
module pipe_ripple_adder_seg_ripple
  import pipe_ripple_adder_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_c_msb
);

  logic [SEG:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
    fa_t w_fa;
    assign w_fa           = full_add(i_a[gi], i_b[gi], w_carry[gi]);
    assign o_sum[gi]      = w_fa.sum;
    assign w_carry[gi+1]  = w_fa.cout;
  end

  assign o_cout  = w_carry[SEG];
  assign o_c_msb = w_carry[SEG-1];

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit segment per stage, carry registered
// between stages, single global enable giving full backpressure.
module pipe_ripple_adder
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if ((WIDTH % SEG) != 0) begin : g_width_check
    $error("pipe_ripple_adder: WIDTH must be a multiple of SEG");
  end

  logic             w_en;
  logic [WIDTH-1:0] w_b_in;
  logic             w_c_in;

  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;
  // Subtract as a + ~b + 1; the operand is inverted once, before it enters the pipe.
  assign w_b_in   = b ^ {WIDTH{sub}};
  assign w_c_in   = sub | ci;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO = gi * SEG;
    localparam int HI = LO + SEG;

    logic [SEG-1:0] w_a_seg;
    logic [SEG-1:0] w_b_seg;
    logic [SEG-1:0] w_sum;
    logic           w_cin;
    logic           w_vin;
    logic           w_cout;
    logic           w_c_msb;
    logic [HI-1:0]  w_s_next;

    logic           r_v;
    logic           r_c;
    logic [HI-1:0]  r_s;

    if (gi == 0) begin : g_src
      assign w_a_seg  = a[SEG-1:0];
      assign w_b_seg  = w_b_in[SEG-1:0];
      assign w_cin    = w_c_in;
      assign w_vin    = in_valid;
      assign w_s_next = w_sum;
    end else begin : g_src
      assign w_a_seg  = g_stage[gi-1].g_fwd.r_a[HI-1:LO];
      assign w_b_seg  = g_stage[gi-1].g_fwd.r_b[HI-1:LO];
      assign w_cin    = g_stage[gi-1].r_c;
      assign w_vin    = g_stage[gi-1].r_v;
      assign w_s_next = {w_sum, g_stage[gi-1].r_s};
    end

    pipe_ripple_adder_seg_ripple #(
      .SEG (SEG)
    ) u_seg (
      .i_a     (w_a_seg),
      .i_b     (w_b_seg),
      .i_cin   (w_cin),
      .o_sum   (w_sum),
      .o_cout  (w_cout),
      .o_c_msb (w_c_msb)
    );

    // Bubbles shift with the data so occupancy never needs tracking separately.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_en) begin
        r_v <= w_vin;
        r_c <= w_cout;
        r_s <= w_s_next;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [WIDTH-1:HI] w_a_up;
      logic [WIDTH-1:HI] w_b_up;
      logic [WIDTH-1:HI] r_a;
      logic [WIDTH-1:HI] r_b;
      logic              w_unused_c_msb;

      assign w_unused_c_msb = w_c_msb;

      if (gi == 0) begin : g_up
        assign w_a_up = a[WIDTH-1:HI];
        assign w_b_up = w_b_in[WIDTH-1:HI];
      end else begin : g_up
        assign w_a_up = g_stage[gi-1].g_fwd.r_a[WIDTH-1:HI];
        assign w_b_up = g_stage[gi-1].g_fwd.r_b[WIDTH-1:HI];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_en) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_en) begin
          r_ovf <= w_cout ^ w_c_msb;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].r_v;
  assign s         = g_stage[STAGES-1].r_s;
  assign co        = g_stage[STAGES-1].r_c;
  assign ovf       = g_stage[STAGES-1].g_last.r_ovf;

endmodule
